// File: rtl/inst_stream_sequencer.sv
// Program-buffer instruction source for the 5-stage MIPS core: load entries, then issue one slot per clock.
// Define INST_HAZARD_STALL_EN to auto-insert NOPs on register hazards within a HAZ_DEPTH-slot window.
module inst_stream_sequencer #(
  parameter int DEPTH     = 64,
  parameter int GAP_W     = 4,
  parameter int LOOP_W    = 8,
  parameter int HAZ_DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [31:0]            ld_inst,
  input  logic [GAP_W-1:0]       ld_gap,
  input  logic                   start,
  input  logic                   clear,
  input  logic [LOOP_W-1:0]      loops,
  output logic [31:0]            inst,
  output logic                   inst_valid,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            issued_cnt,
  output logic [$clog2(DEPTH):0] prog_len
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  state_t            state_q;
  logic [LW-1:0]     prog_len_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [LOOP_W-1:0] pass_q;
  logic [GAP_W-1:0]  gap_q;
  logic              stall_q;
  logic [31:0]       inst_q, cnt_q;
  logic              valid_q, done_q;

  logic [31:0]       mem_inst [DEPTH];
  logic [GAP_W-1:0]  mem_gap  [DEPTH];

  logic              ld_fire, last, fin, step, present, phaz;
  logic [PW-1:0]     nxt_ptr, pidx;
  logic [GAP_W-1:0]  cur_gap;
  logic [31:0]       pinst;

  assign ld_ready = (state_q == IDLE) && (prog_len_q < LW'(DEPTH)) && !start && !clear;
  assign ld_fire  = ld_valid && ld_ready;

  always_ff @(posedge clk)
    if (ld_fire) begin
      mem_inst[prog_len_q[PW-1:0]] <= ld_inst;
      mem_gap[prog_len_q[PW-1:0]]  <= ld_gap;
    end

  assign last    = ({1'b0, rd_ptr_q} == prog_len_q - LW'(1));
  assign nxt_ptr = last ? '0 : rd_ptr_q + PW'(1);
  assign fin     = last && (pass_q <= LOOP_W'(1));
  assign cur_gap = mem_gap[rd_ptr_q];
  // step: the current entry (including its trailing gap) is finished this cycle
  assign step    = (state_q == RUN && !stall_q && cur_gap == '0) ||
                   (state_q == GAP && gap_q == GAP_W'(1));
  // a stalled entry keeps rd_ptr; otherwise the next entry is the candidate
  assign pidx    = stall_q ? rd_ptr_q : nxt_ptr;
  assign pinst   = mem_inst[pidx];
  assign present = (state_q == RUN && stall_q) || (step && !fin);

`ifdef INST_HAZARD_STALL_EN
  logic [HAZ_DEPTH-1:0][4:0] win_q;  // [0] = destination of the slot now on inst

  function automatic logic [4:0] dst_of(input logic [31:0] w);
    case (w[31:26])
      6'h00:                             dst_of = w[15:11];
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23: dst_of = w[20:16];
      default:                           dst_of = 5'd0;
    endcase
  endfunction

  always_comb begin
    phaz = 1'b0;
    for (int k = 0; k < HAZ_DEPTH; k++)
      if (win_q[k] != 5'd0 && (win_q[k] == pinst[25:21] || win_q[k] == pinst[20:16]))
        phaz = 1'b1;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) win_q <= '0;
    else if (clear) win_q <= '0;
    else if (state_q == IDLE && start) begin
      win_q    <= '0;
      win_q[0] <= dst_of(mem_inst[0]);
    end else if (state_q == RUN || state_q == GAP)
      win_q <= {win_q[HAZ_DEPTH-2:0], (present && !phaz) ? dst_of(pinst) : 5'd0};
`else
  assign phaz = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      prog_len_q <= '0;
      rd_ptr_q   <= '0;
      pass_q     <= '0;
      gap_q      <= '0;
      stall_q    <= 1'b0;
      inst_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
    end else if (clear) begin
      state_q    <= IDLE;
      prog_len_q <= '0;
      rd_ptr_q   <= '0;
      pass_q     <= '0;
      gap_q      <= '0;
      stall_q    <= 1'b0;
      inst_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inst_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ld_fire) prog_len_q <= prog_len_q + LW'(1);
          if (start) begin
            rd_ptr_q <= '0;
            stall_q  <= 1'b0;
            if (prog_len_q != '0) begin
              state_q <= RUN;
              pass_q  <= (loops == '0) ? LOOP_W'(1) : loops;
              inst_q  <= mem_inst[0];
              valid_q <= 1'b1;
              cnt_q   <= 32'd1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              cnt_q   <= '0;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: begin
          if (present) begin
            state_q <= RUN;
            if (!stall_q) begin
              rd_ptr_q <= nxt_ptr;
              if (last) pass_q <= pass_q - LOOP_W'(1);
            end
            if (phaz) stall_q <= 1'b1;
            else begin
              stall_q <= 1'b0;
              inst_q  <= pinst;
              valid_q <= 1'b1;
              cnt_q   <= cnt_q + 32'd1;
            end
          end else if (step) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (state_q == RUN) begin
            state_q <= GAP;
            gap_q   <= cur_gap;
          end else
            gap_q <= gap_q - GAP_W'(1);
        end
      endcase
    end

  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign busy       = (state_q == RUN) || (state_q == GAP);
  assign done       = done_q;
  assign issued_cnt = cnt_q;
  assign prog_len   = prog_len_q;
endmodule

// File: tb/tb_inst_stream_sequencer.sv
// Scoreboard bench: a slot-list reference model fills exp_q at start; a negedge monitor pops and compares.
module tb_inst_stream_sequencer;
  localparam int DEPTH = 64, GAP_W = 4, LOOP_W = 8, HAZ_DEPTH = 3;

  logic clk = 1'b0, reset = 1'b1, ld_valid = 1'b0, start = 1'b0, clear = 1'b0;
  logic [31:0] ld_inst = '0;
  logic [GAP_W-1:0] ld_gap = '0;
  logic [LOOP_W-1:0] loops = '0;
  logic ld_ready, inst_valid, busy, done;
  logic [31:0] inst, issued_cnt;
  logic [$clog2(DEPTH):0] prog_len;

  inst_stream_sequencer #(.DEPTH(DEPTH), .GAP_W(GAP_W), .LOOP_W(LOOP_W), .HAZ_DEPTH(HAZ_DEPTH)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_inst(ld_inst),
    .ld_gap(ld_gap), .start(start), .clear(clear), .loops(loops), .inst(inst),
    .inst_valid(inst_valid), .busy(busy), .done(done), .issued_cnt(issued_cnt), .prog_len(prog_len));

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] inst; logic v; logic d; } slot_t;
  slot_t exp_q[$];
  slot_t mon_e;
  logic [31:0] pi[$];
  int pg[$];
  int win[$];
  int exp_cnt;
  int n_cmp = 0, n_bad = 0;
  bit mon_en = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!reset && mon_en && (busy || done)) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_slot: got inst=%0h v=%0b d=%0b want none", inst, inst_valid, done);
      end else begin
        mon_e = exp_q.pop_front();
        chk("slot", {29'b0, inst, inst_valid, done, busy}, {29'b0, mon_e, ~mon_e.d});
      end
    end

  function automatic int dst_of(logic [31:0] w);
    case (w[31:26])
      6'h00:                             return int'(w[15:11]);
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23: return int'(w[20:16]);
      default:                           return 0;
    endcase
  endfunction

  function automatic bit haz(logic [31:0] w);
    foreach (win[k])
      if (win[k] != 0 && (win[k] == int'(w[25:21]) || win[k] == int'(w[20:16]))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic emit(logic [31:0] w, logic v, int d);
    exp_q.push_back({w, v, 1'b0});
    win.push_front(d);
    void'(win.pop_back());
  endtask

  // Reference: every pass walks the list; each entry is (stall NOPs), the word, then gap NOPs.
  task automatic build(int L);
    int passes;
    passes = (L == 0) ? 1 : L;
    exp_q.delete(); win.delete(); exp_cnt = 0;
    for (int k = 0; k < HAZ_DEPTH; k++) win.push_back(0);
    if (pi.size() > 0)
      for (int p = 0; p < passes; p++)
        for (int i = 0; i < pi.size(); i++) begin
`ifdef INST_HAZARD_STALL_EN
          while (haz(pi[i])) emit(32'h0, 1'b0, 0);
`endif
          emit(pi[i], 1'b1, dst_of(pi[i]));
          exp_cnt++;
          for (int g = 0; g < pg[i]; g++) emit(32'h0, 1'b0, 0);
        end
    exp_q.push_back({32'h0, 1'b0, 1'b1});
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic load_all(bit rnd_idle);
    for (int i = 0; i < pi.size(); i++) begin
      if (rnd_idle && $urandom_range(0, 2) == 0) tick();
      ld_valid = 1'b1; ld_inst = pi[i]; ld_gap = GAP_W'(pg[i]);
      @(negedge clk);
      chk("ld_ready", 64'(ld_ready), 64'(1));
      @(posedge clk); #1;
      ld_valid = 1'b0;
    end
  endtask

  task automatic go(int L, bit with_ld);
    int seen;
    seen = 0;
    loops = LOOP_W'(L);
    build(L);
    mon_en = 1'b1;
    start = 1'b1;
    if (with_ld) begin
      ld_valid = 1'b1; ld_inst = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("ld_ready_with_start", 64'(ld_ready), 64'(0));
    end
    tick();
    start = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    chk("first_slot_latency", 64'(busy | done), 64'(1));
    if (done) seen = 1;
    for (int c = 0; c < 3000 && seen == 0; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_seen", 64'(seen), 64'(1));
    tick(); tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    chk("issued_cnt", 64'(issued_cnt), 64'(exp_cnt));
    chk("prog_len", 64'(prog_len), 64'(pi.size()));
    mon_en = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_prog(int n);
    pi.delete(); pg.delete();
    for (int i = 0; i < n; i++) begin
      pi.push_back({6'h0D, 5'd0, 5'(8 + i % 8), 16'(i)});
      pg.push_back(0);
    end
  endtask

  initial begin
    int cnt;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_inst", 64'(inst), 64'(0));
    chk("rst_flags", 64'({inst_valid, busy, done}), 64'(0));
    chk("rst_issued", 64'(issued_cnt), 64'(0));
    chk("rst_prog_len", 64'(prog_len), 64'(0));
    reset = 1'b0;
    tick();

    // three dependent MIPS ops, no gaps
    pi = '{32'h2042000A, 32'h20630016, 32'h00434020}; pg = '{0, 0, 0};
    load_all(1'b0);
    go(1, 1'b0);

    // gap of five after the first entry
    do_clear();
    pi = '{32'h2042000A, 32'h20630016}; pg = '{5, 0};
    load_all(1'b0);
    go(1, 1'b0);

    // four entries, three passes, then replay of the retained buffer
    do_clear();
    set_prog(4);
    load_all(1'b1);
    go(3, 1'b0);
    go(2, 1'b0);

    // load refused when start is asserted alongside ld_valid
    do_clear();
    set_prog(2);
    load_all(1'b0);
    go(1, 1'b1);

    // hazard pair: ADDI v0 then ADD t0,v0,v1
    do_clear();
    pi = '{32'h2042000A, 32'h00434020}; pg = '{0, 0};
    load_all(1'b0);
    go(1, 1'b0);

    // fill to DEPTH, overflow attempt, then clear mid-run
    do_clear();
    set_prog(DEPTH);
    load_all(1'b0);
    @(negedge clk);
    chk("full_ld_ready", 64'(ld_ready), 64'(0));
    ld_valid = 1'b1; ld_inst = 32'h1234_5678; tick(); ld_valid = 1'b0;
    chk("full_prog_len", 64'(prog_len), 64'(DEPTH));
    loops = 8'd1; start = 1'b1; tick(); start = 1'b0;
    repeat (9) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    @(negedge clk);
    chk("clr_busy", 64'({busy, inst_valid, done}), 64'(0));
    chk("clr_inst", 64'(inst), 64'(0));
    chk("clr_prog_len", 64'(prog_len), 64'(0));
    chk("clr_issued_hold", 64'(issued_cnt), 64'(10));
    cnt = 0;
    for (int c = 0; c < 20; c++) begin @(negedge clk); if (done || inst_valid) cnt++; end
    chk("clr_no_done", 64'(cnt), 64'(0));

    // start and clear together: clear wins
    set_prog(2);
    load_all(1'b0);
    start = 1'b1; clear = 1'b1; tick(); start = 1'b0; clear = 1'b0;
    @(negedge clk);
    chk("sc_prog_len", 64'(prog_len), 64'(0));
    cnt = 0;
    for (int c = 0; c < 6; c++) begin @(negedge clk); if (done || inst_valid || busy) cnt++; end
    chk("sc_no_issue", 64'(cnt), 64'(0));

    // start with an empty buffer: lone done pulse
    pi.delete(); pg.delete();
    go(1, 1'b0);

    // randomized programs
    for (int t = 0; t < 10; t++) begin
      int n;
      do_clear();
      n = $urandom_range(1, 6);
      pi.delete(); pg.delete();
      for (int i = 0; i < n; i++) begin
        pi.push_back($urandom());
        pg.push_back(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
      end
      load_all(1'b1);
      go($urandom_range(0, 3), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
